serial_adder: RTL

- Bit-serial N-bit adder built around a single 1-bit full-adder cell with a registered carry.
- Accepts two parallel operands plus carry-in, processes one bit per clock, LSB first, and returns the parallel sum and carry-out.
- Sits one level above the 1-bit full-adder cell in the adder hierarchy. It is the area-cheap alternative to the ripple/parallel adders.

---
 rtl/serial_adder.sv | 67 ++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder step per clock, LSB first.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_next;
    logic [CW-1:0]    cnt;
    logic             carry, s, c, accept;

    always_comb begin
        s      = a_sh[0] ^ b_sh[0] ^ carry;
        c      = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        s_next = (s_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
        accept = start && (state == IDLE || state == DONE);
        busy   = state == SHIFT;
        done   = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            state <= SHIFT;
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_next;
            carry <= c;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
                sum   <= s_next;
                cout  <= c;
                state <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule
